pipe_scroller: RTL and testbench

- Consumer of the pipe column generator's `layout` byte.
- On every scroll tick it samples one 8-bit column, shifts it into a COLS-wide playfield, and drives the field to the LED driver.
- Checks the bird pixel against the field column at BIRD_COL and counts pipes cleared.
- Owns the run/crash state for the playfield.

---
 rtl/pipe_field_pkg.sv | 16 +
 rtl/scroll_tick.sv | 30 +++
 rtl/pipe_scroller.sv | 99 +++++++++
 tb/tb_pipe_scroller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_field_pkg.sv
// rtl/pipe_field_pkg.sv - shared constants and types for the pipe playfield
package pipe_field_pkg;

    localparam int ROWS_DEF     = 8;
    localparam int COLS_DEF     = 16;
    localparam int BIRD_COL_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } scroll_state_t;

    typedef logic [ROWS_DEF-1:0] column_t;

endpackage

// File: rtl/scroll_tick.sv
// rtl/scroll_tick.sv - scroll step divider: one-cycle tick every TICK_DIV cycles
module scroll_tick #(
    parameter int TICK_DIV = 512
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    // hold freezes the phase so a frozen playfield resumes nothing mid-step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (!run) begin
            r_count <= '0;
        end else if (!hold) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

    assign tick = run && !hold && (r_count == LAST);

endmodule

// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolls pipe columns through the playfield, detects bird collisions, keeps score
import pipe_field_pkg::*;

module pipe_scroller #(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int TICK_DIV = 512,
    parameter int BIRD_COL = BIRD_COL_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ongoing,
    input  logic                    gameOver,
    input  logic [ROWS-1:0]         layout,
    input  logic [$clog2(ROWS)-1:0] bird_row,
    output logic                    col_take,
    output logic [ROWS*COLS-1:0]    field,
    output logic                    crash,
    output logic [7:0]              score
);

    scroll_state_t          r_state;
    logic [ROWS*COLS-1:0]   r_field;
    logic [7:0]             r_score;
    logic                   r_crash;

    logic                   w_tick;
    logic                   w_hit;
    logic                   w_shift;
    logic [ROWS-1:0]        w_bird_col;

    scroll_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (r_state != IDLE),
        .hold  (r_state == HIT),
        .tick  (w_tick)
    );

    // Collision looks at the registered field, so on a tick cycle it sees the pre-shift column
    assign w_bird_col = r_field[BIRD_COL*ROWS +: ROWS];
    assign w_hit      = (r_state == RUN) && w_bird_col[bird_row];
    assign w_shift    = (r_state == RUN) && w_tick && ongoing && !w_hit && !gameOver;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_field <= '0;
            r_score <= '0;
            r_crash <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_field <= '0;
                    r_crash <= 1'b0;
                    if (ongoing) begin
                        r_state <= RUN;
                        r_score <= '0;
                    end
                end
                RUN: begin
                    if (!ongoing) begin
                        r_state <= IDLE;
                        r_field <= '0;
                        r_crash <= 1'b0;
                    end else if (w_hit || gameOver) begin
                        r_state <= HIT;
                        r_crash <= 1'b1;
                    end else if (w_tick) begin
                        r_field <= {layout, r_field[ROWS*COLS-1:ROWS]};
                        if ((w_bird_col != '0) && (r_score != 8'hFF)) begin
                            r_score <= r_score + 8'd1;
                        end
                    end
                end
                HIT: begin
                    if (!ongoing) begin
                        r_state <= IDLE;
                        r_field <= '0;
                        r_crash <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_field <= '0;
                    r_crash <= 1'b0;
                end
            endcase
        end
    end

    assign col_take = w_shift;
    assign field    = r_field;
    assign crash    = r_crash;
    assign score    = r_score;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - directed bench for pipe_scroller with TICK_DIV = 4
module tb_pipe_scroller;

    logic         clk = 1'b0;
    logic         reset;
    logic         ongoing;
    logic         gameOver;
    logic [7:0]   layout;
    logic [2:0]   bird_row;
    logic         col_take;
    logic [127:0] field;
    logic         crash;
    logic [7:0]   score;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] exp_field;
    logic [7:0]   exp_score;
    logic         saw_take;

    always #5 clk = ~clk;

    pipe_scroller #(
        .ROWS     (8),
        .COLS     (16),
        .TICK_DIV (4),
        .BIRD_COL (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ongoing  (ongoing),
        .gameOver (gameOver),
        .layout   (layout),
        .bird_row (bird_row),
        .col_take (col_take),
        .field    (field),
        .crash    (crash),
        .score    (score)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (col_take) saw_take = 1'b1;
    endtask

    // Waits for the tick cycle, advances the reference field/score, then takes the shift edge
    task automatic wait_tick();
        int n = 0;
        while (col_take !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("tick_seen", col_take, 1'b1);
        if (exp_field[16 +: 8] != 8'h00 && exp_score != 8'hFF) exp_score++;
        exp_field = {layout, exp_field[127:8]};
        step();
        chk("field_model", field, exp_field);
        chk("score_model", score, exp_score);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; ongoing = 1'b1; gameOver = 1'b0;
        layout = 8'hC7; bird_row = 3'd4;
        exp_field = '0; exp_score = '0; saw_take = 1'b0;

        #12;
        chk("rst_field", field, '0);
        chk("rst_score", score, 8'd0);
        chk("rst_crash", crash, 1'b0);
        chk("rst_take", col_take, 1'b0);

        // Test 1: first tick four edges after entering RUN
        reset = 1'b1;
        step();
        chk("t1_take_e1", col_take, 1'b0);
        step(); step();
        chk("t1_take_e3", col_take, 1'b0);
        step();
        chk("t1_take_e4", col_take, 1'b1);
        exp_field = {layout, exp_field[127:8]};
        step();
        chk("t1_col15", field, exp_field);
        chk("t1_take_after", col_take, 1'b0);
        wait_tick();
        wait_tick();
        chk("t1_cols13_15", field[104 +: 24], 24'hC7C7C7);
        chk("t1_col12", field[96 +: 8], 8'h00);

        // Test 2: alternating pipes, bird in the gap
        ongoing = 1'b0;
        step();
        chk("t2_idle_clear", field, '0);
        ongoing = 1'b1;
        step();
        exp_field = '0; exp_score = '0;
        for (int k = 1; k <= 14; k++) begin
            layout = (k % 2 == 1) ? 8'hC7 : 8'h00;
            wait_tick();
        end
        chk("t2_col2", field[16 +: 8], 8'hC7);
        chk("t2_nocrash", crash, 1'b0);
        layout = 8'hC7;
        wait_tick();
        chk("t2_score1", score, 8'd1);
        for (int k = 16; k <= 28; k++) begin
            layout = (k % 2 == 1) ? 8'hC7 : 8'h00;
            wait_tick();
        end
        chk("t2_score7", score, 8'd7);
        chk("t2_nocrash_end", crash, 1'b0);

        // Test 4: external game over, then abort and restart
        gameOver = 1'b1;
        step();
        gameOver = 1'b0;
        chk("t4_crash", crash, 1'b1);
        saw_take = 1'b0;
        repeat (10) step();
        chk("t4_no_take", saw_take, 1'b0);
        chk("t4_frozen", field, exp_field);
        chk("t4_score_hold", score, 8'd7);
        ongoing = 1'b0;
        step();
        chk("t4_idle_crash", crash, 1'b0);
        chk("t4_idle_field", field, '0);
        chk("t4_idle_score", score, 8'd7);
        ongoing = 1'b1;
        step();
        chk("t4_restart_score", score, 8'd0);

        // Test 3: bird on a lit row collides
        bird_row = 3'd0;
        exp_field = '0; exp_score = '0;
        for (int k = 1; k <= 14; k++) begin
            layout = (k % 2 == 1) ? 8'hC7 : 8'h00;
            wait_tick();
        end
        chk("t3_precrash", crash, 1'b0);
        step();
        chk("t3_crash", crash, 1'b1);
        saw_take = 1'b0;
        repeat (24) step();
        chk("t3_no_take", saw_take, 1'b0);
        chk("t3_frozen", field, exp_field);
        chk("t3_score", score, 8'd0);
        chk("t3_crash_hold", crash, 1'b1);
        ongoing = 1'b0;
        step();
        ongoing = 1'b1;
        step();

        // Test 5: score saturation
        bird_row = 3'd4; layout = 8'hC7;
        exp_field = '0; exp_score = '0;
        for (int k = 1; k <= 268; k++) wait_tick();
        chk("t5_score254", score, 8'd254);
        wait_tick();
        chk("t5_score255", score, 8'd255);
        repeat (20) wait_tick();
        chk("t5_sat", score, 8'd255);

        // Test 6: asynchronous reset between edges
        #3;
        reset = 1'b0;
        #1;
        chk("t6_field", field, '0);
        chk("t6_score", score, 8'd0);
        chk("t6_crash", crash, 1'b0);
        ongoing = 1'b0;
        #2;
        reset = 1'b1;
        saw_take = 1'b0;
        repeat (6) step();
        chk("t6_idle_take", saw_take, 1'b0);
        chk("t6_idle_field", field, '0);
        ongoing = 1'b1;
        step(); step(); step();
        chk("t6_take_e3", col_take, 1'b0);
        step();
        chk("t6_take_e4", col_take, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
